e203_exu_alu_dpath_arb: RTL and testbench

Arbiter and sequencer for the shared ALU datapath (adder/shifter/logic/compare with 11 one-hot op selects, two XLEN operands, one XLEN result).
- Three requesters share the datapath: requester 0 = regular ALU, 1 = AGU, 2 = multi-cycle mul/div.
- Arbitration is round-robin.
- A requester can lock the datapath across consecutive cycles for iterative operations.
- The block sits between the EXU sub-units and the shared datapath; the datapath itself stays purely combinational.

---
 rtl/e203_exu_alu_dpath_arb.sv | 87 ++++++++
 tb/tb_e203_exu_alu_dpath_arb.sv | 96 +++++++++
 2 files changed

// File: rtl/e203_exu_alu_dpath_arb.sv
// e203_exu_alu_dpath_arb: round-robin arbiter/sequencer for the shared ALU datapath with lock support
//   clk, rst_n            : clock, synchronous active-low reset
//   rX_valid/ready        : request handshake per requester (0=ALU, 1=AGU, 2=mul/div)
//   rX_op/op1/op2/lock    : request fields; lock keeps ownership after the transfer
//   rX_res                : datapath result broadcast to every requester
//   dp_op/op1/op2, dp_res : shared combinational datapath interface
//   arb_flush             : drops grant this cycle and any lock
//   arb_locked, arb_owner : lock state and last granted requester
module e203_exu_alu_dpath_arb #(
    parameter int XLEN = 32,
    parameter int OPW  = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r0_valid,
    input  logic            r1_valid,
    input  logic            r2_valid,
    output logic            r0_ready,
    output logic            r1_ready,
    output logic            r2_ready,
    input  logic [OPW-1:0]  r0_op,
    input  logic [OPW-1:0]  r1_op,
    input  logic [OPW-1:0]  r2_op,
    input  logic [XLEN-1:0] r0_op1,
    input  logic [XLEN-1:0] r1_op1,
    input  logic [XLEN-1:0] r2_op1,
    input  logic [XLEN-1:0] r0_op2,
    input  logic [XLEN-1:0] r1_op2,
    input  logic [XLEN-1:0] r2_op2,
    input  logic            r0_lock,
    input  logic            r1_lock,
    input  logic            r2_lock,
    output logic [XLEN-1:0] r0_res,
    output logic [XLEN-1:0] r1_res,
    output logic [XLEN-1:0] r2_res,
    output logic [OPW-1:0]  dp_op,
    output logic [XLEN-1:0] dp_op1,
    output logic [XLEN-1:0] dp_op2,
    input  logic [XLEN-1:0] dp_res,
    input  logic            arb_flush,
    output logic            arb_locked,
    output logic [1:0]      arb_owner
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state;
    logic [1:0] owner, rr_ptr, c1, c2, gi;
    logic [2:0] v, l;
    logic       gnt;
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction
    assign v = {r2_valid, r1_valid, r0_valid};
    assign l = {r2_lock, r1_lock, r0_lock};
    // Grant never depends on dp_res; reset and flush suppress any transfer.
    always_comb begin
        c1  = inc3(rr_ptr);
        c2  = inc3(c1);
        gi  = state == LOCKED ? owner : v[rr_ptr] ? rr_ptr : v[c1] ? c1 : c2;
        gnt = (state == LOCKED ? v[owner] : |v) && !arb_flush && rst_n;
    end
    assign r0_ready = gnt && gi == 2'd0;
    assign r1_ready = gnt && gi == 2'd1;
    assign r2_ready = gnt && gi == 2'd2;
    assign dp_op  = !gnt ? '0 : gi == 2'd1 ? r1_op : gi == 2'd2 ? r2_op : r0_op;
    // Idle operands default to requester 0 to limit datapath toggling.
    assign dp_op1 = r1_ready ? r1_op1 : r2_ready ? r2_op1 : r0_op1;
    assign dp_op2 = r1_ready ? r1_op2 : r2_ready ? r2_op2 : r0_op2;
    assign r0_res = dp_res;
    assign r1_res = dp_res;
    assign r2_res = dp_res;
    assign arb_locked = state == LOCKED;
    assign arb_owner  = owner;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (arb_flush) begin
            state <= IDLE;
        end else if (gnt) begin
            owner <= gi;
            state <= l[gi] ? LOCKED : IDLE;
            if (!l[gi])
                rr_ptr <= inc3(gi);
        end
    end
endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// tb_e203_exu_alu_dpath_arb: scoreboard bench for the ALU datapath arbiter
module tb_e203_exu_alu_dpath_arb;
    localparam logic [10:0] OP0 = 11'h004;
    localparam logic [10:0] OP1 = 11'h001;
    localparam logic [10:0] OP2 = 11'h100;
    logic        clk = 1'b0, rst_n = 1'b0, arb_flush = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0, r2_valid = 1'b0;
    logic        r0_ready, r1_ready, r2_ready;
    logic        r0_lock = 1'b0, r1_lock = 1'b0, r2_lock = 1'b0;
    logic [10:0] r0_op = OP0, r1_op = OP1, r2_op = OP2, dp_op;
    logic [31:0] r0_op1 = 32'h10, r1_op1 = 32'h5, r2_op1 = 32'h100;
    logic [31:0] r0_op2 = 32'h1, r1_op2 = 32'h3, r2_op2 = 32'h20;
    logic [31:0] r0_res, r1_res, r2_res, dp_op1, dp_op2, dp_res;
    logic        arb_locked;
    logic [1:0]  arb_owner;
    int          n_cmp = 0, n_err = 0;
    typedef struct {
        string       tag;
        logic [2:0]  rdy;
        logic [10:0] op;
        logic        lk;
        logic [1:0]  own;
    } exp_t;
    exp_t q[$];
    assign dp_res = dp_op1 + dp_op2;
    always #5 clk = ~clk;
    e203_exu_alu_dpath_arb dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready), .r2_ready(r2_ready),
        .r0_op(r0_op), .r1_op(r1_op), .r2_op(r2_op),
        .r0_op1(r0_op1), .r1_op1(r1_op1), .r2_op1(r2_op1),
        .r0_op2(r0_op2), .r1_op2(r1_op2), .r2_op2(r2_op2),
        .r0_lock(r0_lock), .r1_lock(r1_lock), .r2_lock(r2_lock),
        .r0_res(r0_res), .r1_res(r1_res), .r2_res(r2_res),
        .dp_op(dp_op), .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_res(dp_res),
        .arb_flush(arb_flush), .arb_locked(arb_locked), .arb_owner(arb_owner)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic step(input string tag, input logic rn, input logic fl, input logic [2:0] v,
                        input logic [2:0] l, input logic [2:0] er, input logic [10:0] eop,
                        input logic elk, input logic [1:0] eown);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        arb_flush = fl;
        {r2_valid, r1_valid, r0_valid} = v;
        {r2_lock, r1_lock, r0_lock} = l;
        q.push_back('{tag, er, eop, elk, eown});
        #1;
        e = q.pop_front();
        check({e.tag, "_rdy"}, {29'd0, r2_ready, r1_ready, r0_ready}, {29'd0, e.rdy});
        check({e.tag, "_op"}, {21'd0, dp_op}, {21'd0, e.op});
        check({e.tag, "_lk"}, {31'd0, arb_locked}, {31'd0, e.lk});
        check({e.tag, "_own"}, {30'd0, arb_owner}, {30'd0, e.own});
    endtask
    initial begin
        repeat (2) @(posedge clk);
        step("rst",  1, 0, 3'b000, 3'b000, 3'b000, 11'd0, 0, 2'd0);
        step("t1a",  1, 0, 3'b111, 3'b000, 3'b001, OP0, 0, 2'd0);
        step("t1b",  1, 0, 3'b111, 3'b000, 3'b010, OP1, 0, 2'd0);
        step("t1c",  1, 0, 3'b111, 3'b000, 3'b100, OP2, 0, 2'd1);
        step("t1d",  1, 0, 3'b111, 3'b000, 3'b001, OP0, 0, 2'd2);
        step("t2s",  1, 0, 3'b010, 3'b000, 3'b010, OP1, 0, 2'd0);
        step("t2a",  1, 0, 3'b101, 3'b100, 3'b100, OP2, 0, 2'd1);
        step("t2b",  1, 0, 3'b101, 3'b100, 3'b100, OP2, 1, 2'd2);
        step("t2h",  1, 0, 3'b001, 3'b000, 3'b000, 11'd0, 1, 2'd2);
        step("t2c",  1, 0, 3'b101, 3'b100, 3'b100, OP2, 1, 2'd2);
        step("t2d",  1, 0, 3'b101, 3'b100, 3'b100, OP2, 1, 2'd2);
        step("t2e",  1, 0, 3'b101, 3'b000, 3'b100, OP2, 1, 2'd2);
        step("t2f",  1, 0, 3'b101, 3'b000, 3'b001, OP0, 0, 2'd2);
        step("t3",   1, 0, 3'b010, 3'b000, 3'b010, OP1, 0, 2'd0);
        check("t3_op1", dp_op1, 32'h5);
        check("t3_op2", dp_op2, 32'h3);
        check("t3_res", r1_res, 32'h8);
        step("t4s",  1, 0, 3'b100, 3'b000, 3'b100, OP2, 0, 2'd1);
        step("t4a",  1, 0, 3'b100, 3'b100, 3'b100, OP2, 0, 2'd2);
        step("t4f",  1, 1, 3'b101, 3'b100, 3'b000, 11'd0, 1, 2'd2);
        step("t4g",  1, 0, 3'b101, 3'b000, 3'b001, OP0, 0, 2'd2);
        step("t5a",  1, 0, 3'b010, 3'b010, 3'b010, OP1, 0, 2'd0);
        step("t5b",  1, 0, 3'b010, 3'b010, 3'b010, OP1, 1, 2'd1);
        step("t5r",  0, 0, 3'b010, 3'b010, 3'b000, 11'd0, 1, 2'd1);
        step("t5c",  1, 0, 3'b111, 3'b000, 3'b001, OP0, 0, 2'd0);
        for (int i = 0; i < 10; i++)
            step("t6", 1, 0, 3'b000, 3'b000, 3'b000, 11'd0, 0, 2'd0);
        step("t6e",  1, 0, 3'b111, 3'b000, 3'b010, OP1, 0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
